// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, default bit period.
// Used by the TX scheduler now and by the RX block later.
// parity_bit() gives the serial parity bit for a byte in a given mode.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // 50 MHz core clock, 115200 baud
  localparam int DEFAULT_CLK_DIV = 434;

  function automatic logic parity_bit(input logic [7:0] dat, input int mode);
    return (mode == PAR_ODD) ? ~(^dat) : (^dat);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: free-running 0..CLK_DIV-1 counter, tick pulses at terminal count.
// Latency: first tick CLK_DIV cycles after clr drops; no backpressure (free-running).
// Ports: clock, sclr (sync reset), clr (hold counter at 0), tick (one-cycle pulse).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clock,
  input  logic sclr,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = !clr && (cnt_q == LAST);
    cnt_d = cnt_q + 1'b1;
    // Wrapping on the tick itself keeps every bit exactly CLK_DIV long.
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: pops the show-ahead TX FIFO and serializes start/8 data/parity/stop.
// Latency: tx falls one cycle after the pop; tx_done pulses one cycle after the last stop bit.
// Backpressure: pops only in IDLE with enable high and FIFO non-empty; one pop per frame.
// Ports: clock, sclr (sync reset), enable, fifo_empty, fifo_q[7:0] in;
//        fifo_rdreq (combinational), tx (registered), busy, tx_done out.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       sclr,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_q,
  output logic       fifo_rdreq,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  tx_state_t   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        tx_done_q, tx_done_d;
  logic        baud_clr;
  logic        baud_tick;

  // Baud counter is parked at zero while idle, so the pop cycle acts as its clear
  // and the start bit gets a full CLK_DIV cycles.
  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clock (clock),
    .sclr  (sclr),
    .clr   (baud_clr),
    .tick  (baud_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    tx_done_d  = 1'b0;
    fifo_rdreq = 1'b0;
    baud_clr   = (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty && !sclr) begin
          fifo_rdreq = 1'b1;
          shift_d    = fifo_q;
          // Parity is taken from the byte up front; the shifter is empty by then.
          par_d      = parity_bit(fifo_q, PARITY);
          bit_cnt_d  = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            tx_done_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // tx is registered from the next state so the line lines up with state_q.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_done = tx_done_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side controller that drains the UART transmit FIFO and serializes each byte onto the `tx` line as an asynchronous frame: start bit, 8 data bits LSB first, optional parity, then stop bit(s). It sits between the show-ahead 16-deep UART FIFO and the board pin. It is the FIFO's only reader and owns its `rdreq`.

## Interface
- `CLK_DIV`, 434: clock cycles per bit (50 MHz / 115200); legal range 2..65535.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `sclr`  in  1  reset, synchronous, active-high.
- `enable`  in  1  permits starting a new frame; sampled only in IDLE.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_q`  in  8  FIFO head byte; valid whenever `fifo_empty` = 0 (show-ahead).
- `fifo_rdreq`  out  1  pop strobe, combinational, one cycle per frame.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  high from the cycle after the pop through the last stop-bit cycle.
- `tx_done`  out  1  one-cycle pulse in the first cycle after the final stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx` = 1.
  - If `enable` && !`fifo_empty`: assert `fifo_rdreq`, latch `fifo_q` into the shift register, clear the bit counter and the baud counter, and go to START.
  - Otherwise hold.
- **START**: `tx` = 0 for `CLK_DIV` cycles, then go to DATA.
- **DATA**
  - `tx` = shift_reg[0].
  - Shift right every `CLK_DIV` cycles.
  - After 8 bits, go to PARITY if `PARITY` != 0, else go to STOP.
- **PARITY**
  - Drive XOR of the latched byte for even parity, or its inverse for odd parity.
  - Hold for `CLK_DIV` cycles, then go to STOP.
- **STOP**: `tx` = 1 for `STOP_BITS`*`CLK_DIV` cycles, then go to IDLE and pulse `tx_done`.
- Baud counter
  - Width $clog2(`CLK_DIV`).
  - Counts 0..`CLK_DIV`-1; the bit boundary is at terminal count, where the counter wraps to 0.
  - The bit counter is 4 bits.
- `enable` deasserted mid-frame: the current frame completes; no new pop follows.
- `fifo_empty` rising mid-frame: no effect on the current frame.
- `fifo_rdreq` is never asserted while `fifo_empty` = 1 or while not in IDLE.
- `sclr` mid-frame:
  - The next cycle has state IDLE, `tx` = 1, and `busy` = `tx_done` = 0.
  - The byte in flight is lost.
  - `fifo_rdreq` = 0 during the `sclr` cycle.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `tx_done` = 0, `fifo_rdreq` = 0, state IDLE, all counters 0.
- Pop at cycle P → `tx` falls at P+1.
- Frame length = (1 + 8 + (`PARITY` != 0) + `STOP_BITS`) * `CLK_DIV` cycles, measured from P+1.
- `tx_done` is high in cycle P+1+frame length. The FSM is in IDLE that same cycle and may pop again, so the minimum inter-frame gap is 1 clock of idle-high.
- Each bit is held for exactly `CLK_DIV` cycles with no cumulative drift.
- A FIFO write in the same cycle as the pop is legal. The controller relies on the FIFO handling simultaneous read and write.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum.
  - Parity encodings PAR_NONE/PAR_EVEN/PAR_ODD.
  - Default `CLK_DIV` constant, shared with the future RX block.
- One sub-module, `uart_baud_tick`:
  - Parameter `CLK_DIV`.
  - Inputs `clock`, `sclr`, `clr`; output `tick`, a one-cycle pulse at terminal count.
  - Reused by RX.

## Test plan
Sim parameters are `CLK_DIV`=4 unless stated.
- Reset → `tx`=1, `busy`=0; FIFO holding 0xA5 with `enable`=0 → no `rdreq` for 100 cycles.
- 0x55, `enable`=1, `PARITY`=0 → one `rdreq` pulse. `tx` sequence per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1. `tx_done` at pop+41.
- 0x03 with `PARITY`=1, then `PARITY`=2 → parity bit 0 for even, 1 for odd. Frame is 11 bits = 44 cycles.
- Three bytes 0x01, 0x80, 0xFF queued, `STOP_BITS`=2 → three frames of 44 cycles, each followed by exactly 1 idle cycle. Exactly 3 `rdreq` pulses. `fifo_empty` high after the third pop.
- `sclr` at cycle 10 of a frame → `tx`=1 next cycle, no `tx_done`. A remaining queued byte starts cleanly after `sclr` releases.
- `enable` dropped at cycle 5 of a frame with 2 bytes queued → current frame finishes. No further `rdreq` until `enable` returns.
